// File: rtl/dp_operand_packer_pkg.sv
// Shared types and sizing helpers for the dot-product operand packer and its engine.
// Default operand widths here must match the engine instance they feed.
package dp_operand_packer_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_e;

  localparam int DEF_PIXEL_N     = 10;
  localparam int DEF_PIXEL_SIZE  = 10;
  localparam int DEF_WEIGHT_SIZE = 19;
  localparam int DEF_VAL_SIZE    = 26;
  localparam int DEF_RST_CYCLES  = 3;
  localparam int DEF_DP_LATENCY  = 128;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int clog2w(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dp_operand_packer.sv
// Packs (pixel, weight) pairs into engine vectors, pulses engine reset, waits a fixed latency and returns the result.
// Latency: RST_CYCLES+DP_LATENCY cycles from last accept to res_valid; in_ready is low from frame end until the result is taken.
module dp_operand_packer
  import dp_operand_packer_pkg::*;
#(
  parameter int PIXEL_N     = DEF_PIXEL_N,
  parameter int PIXEL_SIZE  = DEF_PIXEL_SIZE,
  parameter int WEIGHT_SIZE = DEF_WEIGHT_SIZE,
  parameter int VAL_SIZE    = DEF_VAL_SIZE,
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int DP_LATENCY  = DEF_DP_LATENCY
) (
  input  logic                           clk,
  input  logic                           GlobalReset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PIXEL_SIZE-1:0]          in_pixel,
  input  logic [WEIGHT_SIZE-1:0]         in_weight,
  input  logic                           in_last,
  output logic [PIXEL_N*PIXEL_SIZE-1:0]  dp_pixels,
  output logic [PIXEL_N*WEIGHT_SIZE-1:0] dp_weights,
  output logic                           dp_rst,
  input  logic [VAL_SIZE-1:0]            dp_value,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [VAL_SIZE-1:0]            res_data
);

  localparam int IDX_W = clog2w(PIXEL_N);
  localparam int CNT_W = clog2w(max3(PIXEL_N, RST_CYCLES, DP_LATENCY) + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXEL_N - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(DP_LATENCY - 1);

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           in_ready_q, in_ready_d;
  logic                           dp_rst_q, dp_rst_d;
  logic                           res_valid_q, res_valid_d;
  logic [VAL_SIZE-1:0]            res_data_q, res_data_d;
  logic [PIXEL_N*PIXEL_SIZE-1:0]  pix_q, pix_d;
  logic [PIXEL_N*WEIGHT_SIZE-1:0] wgt_q, wgt_d;

  assign in_ready   = in_ready_q;
  assign dp_rst     = dp_rst_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign dp_pixels  = pix_q;
  assign dp_weights = wgt_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    dp_rst_d    = dp_rst_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    pix_d       = pix_q;
    wgt_d       = wgt_q;
    case (state_q)
      FILL: begin
        if (in_valid && in_ready_q) begin
          pix_d[int'(idx_q)*PIXEL_SIZE +: PIXEL_SIZE]   = in_pixel;
          wgt_d[int'(idx_q)*WEIGHT_SIZE +: WEIGHT_SIZE] = in_weight;
          idx_d = idx_q + 1'b1;
          if (in_last || idx_q == IDX_LAST) begin
            state_d    = LAUNCH;
            in_ready_d = 1'b0;
            cnt_d      = '0;
          end
        end
      end
      // Engine reset is already high from FILL; hold it for RST_CYCLES more edges.
      LAUNCH: begin
        if (cnt_q == RST_LAST) begin
          cnt_d    = '0;
          dp_rst_d = 1'b0;
          state_d  = WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d       = '0;
          res_data_d  = dp_value;
          res_valid_d = 1'b1;
          state_d     = RESULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESULT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          pix_d       = '0;
          wgt_d       = '0;
          idx_d       = '0;
          dp_rst_d    = 1'b1;
          in_ready_d  = 1'b1;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      state_q     <= FILL;
      idx_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      dp_rst_q    <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      pix_q       <= '0;
      wgt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      dp_rst_q    <= dp_rst_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      pix_q       <= pix_d;
      wgt_q       <= wgt_d;
    end
  end

endmodule

// File: tb/tb_dp_operand_packer.sv
// Bench for dp_operand_packer: behavioural engine model, result scoreboard, launch timing and reset checks.
module tb_dp_operand_packer;

  logic         clk = 1'b0;
  logic         GlobalReset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [9:0]   in_pixel = '0;
  logic [18:0]  in_weight = '0;
  logic         in_last = 1'b0;
  logic [99:0]  dp_pixels;
  logic [189:0] dp_weights;
  logic         dp_rst;
  logic [25:0]  dp_value;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [25:0]  res_data;

  int n_chk = 0;
  int n_pass = 0;
  logic [25:0] exp_q[$];
  logic [9:0]  fp[10];
  logic [18:0] fw[10];

  always #5 clk = ~clk;

  dp_operand_packer dut (
    .clk(clk), .GlobalReset_n(GlobalReset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .in_weight(in_weight), .in_last(in_last),
    .dp_pixels(dp_pixels), .dp_weights(dp_weights), .dp_rst(dp_rst),
    .dp_value(dp_value), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
  );

  // Engine stand-in: result settles 100 cycles after its reset drops, garbage before.
  int eng_cnt = 0;
  always @(posedge clk) begin
    if (dp_rst) eng_cnt <= 0;
    else if (eng_cnt < 1000) eng_cnt <= eng_cnt + 1;
  end

  function automatic logic [25:0] eng_sum(input logic [99:0] p, input logic [189:0] w);
    logic [25:0] s;
    s = '0;
    for (int i = 0; i < 10; i++) s = s + 26'(p[i*10 +: 10]) * 26'(w[i*19 +: 19]);
    return s;
  endfunction

  always_comb dp_value = (eng_cnt >= 100) ? eng_sum(dp_pixels, dp_weights) : 26'h2AAAAAA;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (GlobalReset_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_result", 64'(res_data), 64'h0);
      else chk("res_data", 64'(res_data), 64'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input int n);
    for (int i = 0; i < 10; i++) begin
      chk("dp_pixels_elem", 64'(dp_pixels[i*10 +: 10]), (i < n) ? 64'(fp[i]) : 64'h0);
      chk("dp_weights_elem", 64'(dp_weights[i*19 +: 19]), (i < n) ? 64'(fw[i]) : 64'h0);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_dp_rst", 64'(dp_rst), 64'h1);
    chk("rst_res_valid", 64'(res_valid), 64'h0);
    chk("rst_res_data", 64'(res_data), 64'h0);
    check_vec(0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 10; i++) begin
      fp[i] = 10'($urandom);
      fw[i] = 19'($urandom);
    end
  endtask

  // Entered and left #1 after a clock edge; returns just after the last accepting edge.
  task automatic send_frame(input int n, input bit use_last, input bit gapped);
    logic [25:0] sum;
    int k;
    int guard;
    bit acc;
    sum = '0;
    k = 0;
    guard = 0;
    for (int i = 0; i < n; i++) sum = sum + 26'(fp[i]) * 26'(fw[i]);
    exp_q.push_back(sum);
    while (k < n && guard < 200) begin
      guard++;
      chk("fill_in_ready", 64'(in_ready), 64'h1);
      if (gapped && guard[0] == 1'b0) begin
        in_valid = 1'b0;
      end else begin
        in_valid  = 1'b1;
        in_pixel  = fp[k];
        in_weight = fw[k];
        in_last   = use_last && (k == n - 1);
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("accept_count", 64'(k), 64'(n));
  endtask

  // From just after last accept edge T: dp_rst high through T+3, res_valid after T+131.
  task automatic check_launch(input int n);
    int c;
    for (int i = 0; i < 3; i++) begin
      chk("launch_dp_rst_hi", 64'(dp_rst), 64'h1);
      chk("launch_in_ready", 64'(in_ready), 64'h0);
      tick();
    end
    chk("wait_dp_rst_lo", 64'(dp_rst), 64'h0);
    check_vec(n);
    c = 3;
    while (!res_valid && c < 400) begin
      tick();
      c++;
    end
    chk("res_latency", 64'(c), 64'd131);
  endtask

  task automatic take_result();
    tick();
    chk("post_res_valid", 64'(res_valid), 64'h0);
    chk("post_in_ready", 64'(in_ready), 64'h1);
    chk("post_dp_rst", 64'(dp_rst), 64'h1);
    check_vec(0);
  endtask

  task automatic async_reset();
    #2 GlobalReset_n = 1'b0;
    #1;
    check_reset_state();
    exp_q.delete();
    #2 GlobalReset_n = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #13;
    check_reset_state();
    GlobalReset_n = 1'b1;
    tick();

    // Full frame: pixels 1..10, weights 2.
    for (int i = 0; i < 10; i++) begin
      fp[i] = 10'(i + 1);
      fw[i] = 19'd2;
    end
    res_ready = 1'b1;
    send_frame(10, 1'b0, 1'b0);
    check_launch(10);
    take_result();

    // Short frame ending on in_last.
    fill_random();
    send_frame(4, 1'b1, 1'b0);
    check_launch(4);
    take_result();

    // Result backpressure with ignored input pulses.
    fill_random();
    res_ready = 1'b0;
    send_frame(10, 1'b0, 1'b0);
    check_launch(10);
    for (int j = 0; j < 20; j++) begin
      chk("bp_res_valid", 64'(res_valid), 64'h1);
      chk("bp_res_data", 64'(res_data), (exp_q.size() > 0) ? 64'(exp_q[0]) : 64'hDEAD);
      chk("bp_in_ready", 64'(in_ready), 64'h0);
      in_valid  = j[0];
      in_pixel  = 10'h3FF;
      in_weight = 19'h7FFFF;
      tick();
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    take_result();

    // Gapped input.
    fill_random();
    send_frame(10, 1'b0, 1'b1);
    check_launch(10);
    take_result();

    // Reset mid-WAIT, then a clean frame.
    fill_random();
    send_frame(10, 1'b0, 1'b0);
    repeat (50) tick();
    async_reset();
    fill_random();
    send_frame(10, 1'b0, 1'b0);
    check_launch(10);
    take_result();

    // Reset mid-FILL after 3 pairs, then a clean frame.
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_pixel  = 10'(100 + i);
      in_weight = 19'(500 + i);
      tick();
    end
    in_valid = 1'b0;
    async_reset();
    fill_random();
    send_frame(10, 1'b0, 1'b0);
    check_launch(10);
    take_result();

    chk("sb_empty", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
